// File: rtl/elementwise_array_mult_pkg.sv
// Shared types and sizing for the 6x6 element-wise fixed-point multiplier.
// Q10.16 by default; products are 2*WIDTH bits before scaling back down.
package elementwise_array_mult_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 6;
    localparam int WIDTH   = 27;
    localparam int FRAC    = 16;
    localparam int LATENCY = 3;
    localparam int PROD_W  = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0]  elem_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef elem_t [ROWS-1:0][COLS-1:0] arr_t;

endpackage

// File: rtl/fx_mult_lane.sv
// One signed fixed-point multiply lane: operand reg, exact product reg, scaled result reg (3 cycles).
// No handshake; en stalls every stage together, rst clears all stages and wins over en.
module fx_mult_lane
    import elementwise_array_mult_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  elem_t a_i,
    input  elem_t b_i,
    output elem_t res_o
);

    elem_t a_q;
    elem_t b_q;
    prod_t prod_q;
    prod_t prod_d;
    elem_t res_q;
    elem_t res_d;
    prod_t a_ext;
    prod_t b_ext;

    // Sign-extend first so the product is the exact 54-bit result; the
    // arithmetic shift floors toward -inf and the narrowing cast wraps.
    always_comb begin
        a_ext  = a_q;
        b_ext  = b_q;
        prod_d = a_ext * b_ext;
        res_d  = elem_t'(prod_q >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            res_q  <= '0;
        end else if (en) begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/elementwise_array_mult.sv
// Hadamard product of two ROWSxCOLS fixed-point arrays, 3 enabled cycles latency, throughput 1.
// No backpressure: en is a global stall, rst clears the whole pipeline synchronously.
module elementwise_array_mult
    import elementwise_array_mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  arr_t dataa,
    input  arr_t datab,
    output arr_t result
);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            fx_mult_lane u_lane (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .a_i   (dataa[gi][gj]),
                .b_i   (datab[gi][gj]),
                .res_o (result[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_elementwise_array_mult.sv
// Scoreboard bench: driver queues hand-computed expected arrays, monitor checks result every cycle.
module tb_elementwise_array_mult;
    import elementwise_array_mult_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    arr_t dataa;
    arr_t datab;
    arr_t result;

    elementwise_array_mult dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dataa  (dataa),
        .datab  (datab),
        .result (result)
    );

    always #5 clk = ~clk;

    arr_t  exp_q[$];
    arr_t  exp_cur;
    int    fill  = 0;
    bit    armed = 0;
    int    total = 0;
    int    bad   = 0;
    string tag   = "init";

    function automatic arr_t uni(input int v);
        arr_t a;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                a[i][j] = elem_t'(v);
        return a;
    endfunction

    // Monitor: tracks enabled edges since reset to know when a queued result is due.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            fill    = 0;
            exp_cur = '0;
            armed   = 1'b1;
        end else if (en && armed) begin
            if (fill >= LATENCY - 1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s scoreboard empty when a result was due", tag);
                end else begin
                    exp_cur = exp_q.pop_front();
                end
            end else begin
                fill++;
            end
        end
        #1;
        if (armed) begin
            bit    ok;
            int    bi;
            int    bj;
            elem_t got;
            elem_t want;
            ok = 1'b1;
            bi = 0;
            bj = 0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    if (ok && result[i][j] !== exp_cur[i][j]) begin
                        ok = 1'b0;
                        bi = i;
                        bj = j;
                    end
            total++;
            if (!ok) begin
                bad++;
                got  = result[bi][bj];
                want = exp_cur[bi][bj];
                $display("FAIL %s lane[%0d][%0d] got=%0d want=%0d", tag, bi, bj, got, want);
            end
        end
    end

    task automatic step(input arr_t a, input arr_t b, input arr_t e, input logic en_v, input logic rst_v);
        @(negedge clk);
        dataa = a;
        datab = b;
        en    = en_v;
        rst   = rst_v;
        if (en_v && !rst_v) exp_q.push_back(e);
    endtask

    task automatic issue(input int a, input int b, input int e);
        step(uni(a), uni(b), uni(e), 1'b1, 1'b0);
    endtask

    // Directed scalar vectors (applied to all lanes): a, b, expected raw result.
    int vec_a[10] = '{65536,  -98304, -1, 1, 2097152, 196608, 98304,  1048576,   -65536, -1};
    int vec_b[10] = '{65536,  131072,  1, 1, 4194304, -65536, 98304,  4194304,   -65536, -1};
    int vec_e[10] = '{65536, -196608, -1, 0, 0,       -196608, 147456, -67108864, 65536,  0};

    initial begin
        arr_t la;
        arr_t lb;
        arr_t le;
        rst   = 1'b1;
        en    = 1'b0;
        dataa = '0;
        datab = '0;

        tag = "reset";
        step(uni(0), uni(0), uni(0), 1'b0, 1'b1);
        step(uni(0), uni(0), uni(0), 1'b0, 1'b1);
        step(uni(0), uni(0), uni(0), 1'b0, 1'b0);

        tag = "unity";
        for (int k = 0; k < 4; k++) issue(65536, 65536, 65536);

        tag = "stream";
        for (int k = 0; k < 10; k++) issue(vec_a[k], vec_b[k], vec_e[k]);

        tag = "lanes";
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                la[i][j] = elem_t'((i * COLS + j + 1) << 16);
                lb[i][j] = elem_t'(2 << 16);
                le[i][j] = elem_t'((2 * (i * COLS + j + 1)) << 16);
            end
        step(la, lb, le, 1'b1, 1'b0);
        issue(0, 0, 0);
        issue(0, 0, 0);
        issue(0, 0, 0);

        tag = "stall";
        issue(65536, 196608, 196608);
        for (int k = 0; k < 5; k++) step(uni(12345), uni(777), uni(0), 1'b0, 1'b0);
        issue(65536, 65536, 65536);
        issue(65536, 65536, 65536);
        issue(0, 0, 0);

        tag = "rst_en";
        issue(131072, 131072, 262144);
        issue(196608, 131072, 393216);
        step(uni(65536), uni(65536), uni(0), 1'b1, 1'b1);
        issue(-131072, 65536, -131072);
        issue(0, 0, 0);
        issue(0, 0, 0);
        issue(0, 0, 0);

        tag = "rst_noen";
        issue(131072, 131072, 262144);
        issue(196608, 131072, 393216);
        step(uni(65536), uni(65536), uni(0), 1'b0, 1'b0);
        step(uni(65536), uni(65536), uni(0), 1'b0, 1'b1);
        step(uni(65536), uni(65536), uni(0), 1'b0, 1'b0);
        issue(98304, -131072, -196608);
        issue(0, 0, 0);
        issue(0, 0, 0);
        issue(0, 0, 0);
        step(uni(0), uni(0), uni(0), 1'b0, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elementwise_array_mult.md
Name: elementwise_array_mult

Overview:
- Pipelined element-wise (Hadamard) multiplier for two 6x6 arrays of signed 27-bit fixed-point values.
- Produces 36 products in parallel, one per element position.
- Serves the full-Jacobian matrix datapath as its scalar/array multiply resource, alongside the 6x6 matrix multiplier.
- Fixed latency and a global clock enable; no handshake.

Parameters:
- ROWS, 6, number of array rows
- COLS, 6, number of array columns
- WIDTH, 27, bits per element, two's complement
- FRAC, 16, fractional bits of the fixed-point format (Q10.16 at default)
- LATENCY, 3, enabled clock cycles from operand capture to result

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  clock enable; the pipeline advances only when en=1
- dataa  in  ROWS x COLS x WIDTH  operand A array, signed
- datab  in  ROWS x COLS x WIDTH  operand B array, signed
- result  out  ROWS x COLS x WIDTH  signed product array: result[i][j] = A[i][j]*B[i][j] in fixed point

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1, every pipeline register clears to 0, so result = all zeros on the next cycle.
  - rst has priority over en. It is honoured even when en=0.
- Enable:
  - When en=0 (and rst=0), all pipeline registers hold and result is unchanged.
  - When en=1, each stage advances one step.
- Pipeline, per element, in enabled cycles:
  - stage 1 registers dataa and datab.
  - stage 2 registers the full signed product, 2*WIDTH=54 bits.
  - stage 3 registers the scaled result.
  - Operands sampled on enabled edge k appear on result after enabled edge k+2, i.e. LATENCY=3 enabled edges counting the capture edge.
  - A new operand set can be accepted every enabled cycle (throughput 1).
- Arithmetic:
  - Signed 27x27 multiply, exact 54-bit product.
  - Arithmetic shift right by FRAC. This truncates toward negative infinity; no rounding.
  - Keep the low WIDTH bits. Overflow wraps, with no saturation.
- Independence: all ROWS*COLS lanes use identical logic and must not interact.
- Reset mid-operation: all in-flight products are discarded. Operands presented on the reset edge are not captured. The first valid result follows LATENCY enabled cycles after rst deasserts.
- Simultaneous rst=1 and en=1: reset wins.
- No X propagation after reset: result is fully defined from the first post-reset cycle.

Decomposition:
- Shared package holds:
  - constants ROWS, COLS, WIDTH, FRAC;
  - typedef elem_t (signed WIDTH-bit);
  - typedef arr_t (ROWS x COLS of elem_t), used for dataa, datab and result.
- One sub-module, fx_mult_lane: a single-element pipelined signed fixed-point multiplier with clk/rst/en, generated ROWS*COLS times by a generate loop in the top.

Test Plan:
- Reset: load nonzero operands, pulse rst for 1 cycle with en=1 -> result is all 0 on the next cycle and stays 0 until new products emerge.
- Unity: every element A=65536 (1.0), B=65536, en held high -> after 3 enabled edges every result=65536. Before that, result=0.
- Sign and truncation:
  - A=-98304 (-1.5), B=131072 (2.0) -> -196608 (-3.0).
  - A=-1, B=1 (raw) -> -1, showing floor truncation.
  - A=1, B=1 -> 0.
- Lane independence: A[i][j]=(i*6+j+1)<<16, B[i][j]=2<<16 -> result[i][j]=(2*(i*6+j+1))<<16 for all 36 positions.
- Enable stall: present 1.0*3.0, hold en=0 for 5 cycles after the first enabled edge, then re-enable -> result is unchanged during the stall and reaches 196608 only after 2 more enabled edges.
- Overflow wrap: A=32.0 (2097152), B=64.0 (4194304) -> result=0 (2^27 wraps). Back-to-back streaming of distinct operand sets on consecutive enabled cycles -> results appear in order, one per cycle.
